// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I decode plus ID/EX, EX/MEM and MEM/WB control registers with a hazard unit.
// Build option FORWARD_EN: forward results from the Memory/Writeback stages to Execute instead of stalling on them.
module pipelined_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_d,
    input  logic                  zero_e,
    output logic                  reg_write_e,
    output logic                  reg_write_m,
    output logic                  reg_write_w,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  alu_src_e,
    output logic [2:0]            imm_src_d,
    output logic                  mem_write_m,
    output logic [1:0]            result_src_w,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic [REG_ADDR_W-1:0] rd_m,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic                  pc_src_e,
    output logic                  jalr_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  illegal_d
);
    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic [3:0]            alu_ctrl;
        logic                  alu_src;
        logic                  branch;
        logic                  jump;
        logic                  jalr;
        logic                  f3b0;
        logic [REG_ADDR_W-1:0] rd;
    } ctrl_t;

    logic [6:0]            w_op;
    logic [2:0]            w_f3;
    logic                  w_f7b5;
    logic [3:0]            w_alu_f3;
    logic                  w_use1;
    logic                  w_use2;
    logic [REG_ADDR_W-1:0] w_rs1_d;
    logic [REG_ADDR_W-1:0] w_rs2_d;
    ctrl_t                 w_ctrl_d;
    ctrl_t                 r_e;
    logic                  r_reg_write_m;
    logic                  r_mem_write_m;
    logic [1:0]            r_result_src_m;
    logic [REG_ADDR_W-1:0] r_rd_m;
    logic                  r_reg_write_w;
    logic [1:0]            r_result_src_w;
    logic [REG_ADDR_W-1:0] r_rd_w;
    logic                  w_hit_e;
    logic                  w_stall;
    logic                  w_unused;

    assign w_op     = instr_d[6:0];
    assign w_f3     = instr_d[14:12];
    assign w_f7b5   = instr_d[30];
    assign w_unused = &{1'b0, instr_d[31], instr_d[29:25]};

    // ALU operation implied by funct3; subtract only for R-type, sra for either shift form
    always_comb begin
        case (w_f3)
            3'b000:  w_alu_f3 = (w_op == 7'b0110011 && w_f7b5) ? 4'b0001 : 4'b0000;
            3'b001:  w_alu_f3 = 4'b0110;
            3'b010:  w_alu_f3 = 4'b0101;
            3'b011:  w_alu_f3 = 4'b1001;
            3'b100:  w_alu_f3 = 4'b0100;
            3'b101:  w_alu_f3 = w_f7b5 ? 4'b1000 : 4'b0111;
            3'b110:  w_alu_f3 = 4'b0011;
            default: w_alu_f3 = 4'b0010;
        endcase
    end

    // Main decoder; anything unsupported leaves the all-zero bubble and flags illegal
    always_comb begin
        w_ctrl_d  = '0;
        imm_src_d = 3'b000;
        illegal_d = 1'b0;
        w_use1    = 1'b0;
        w_use2    = 1'b0;
        case (w_op)
            7'b0110011: begin
                w_ctrl_d.reg_write = 1'b1;
                w_ctrl_d.alu_ctrl  = w_alu_f3;
                w_use1             = 1'b1;
                w_use2             = 1'b1;
            end
            7'b0010011: begin
                w_ctrl_d.reg_write = 1'b1;
                w_ctrl_d.alu_src   = 1'b1;
                w_ctrl_d.alu_ctrl  = w_alu_f3;
                w_use1             = 1'b1;
            end
            7'b0000011: begin
                w_ctrl_d.reg_write  = 1'b1;
                w_ctrl_d.result_src = 2'b01;
                w_ctrl_d.alu_src    = 1'b1;
                w_use1              = 1'b1;
            end
            7'b0100011: begin
                w_ctrl_d.mem_write = 1'b1;
                w_ctrl_d.alu_src   = 1'b1;
                imm_src_d          = 3'b001;
                w_use1             = 1'b1;
                w_use2             = 1'b1;
            end
            7'b1100011: begin
                if (w_f3[2:1] == 2'b00) begin
                    w_ctrl_d.branch   = 1'b1;
                    w_ctrl_d.alu_ctrl = 4'b0001;
                    w_ctrl_d.f3b0     = w_f3[0];
                    imm_src_d         = 3'b010;
                    w_use1            = 1'b1;
                    w_use2            = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            7'b1101111: begin
                w_ctrl_d.reg_write  = 1'b1;
                w_ctrl_d.jump       = 1'b1;
                w_ctrl_d.result_src = 2'b10;
                imm_src_d           = 3'b011;
            end
            7'b1100111: begin
                w_ctrl_d.reg_write  = 1'b1;
                w_ctrl_d.jump       = 1'b1;
                w_ctrl_d.jalr       = 1'b1;
                w_ctrl_d.result_src = 2'b10;
                w_ctrl_d.alu_src    = 1'b1;
                w_use1              = 1'b1;
            end
            7'b0110111: begin
                w_ctrl_d.reg_write = 1'b1;
                w_ctrl_d.alu_src   = 1'b1;
                w_ctrl_d.alu_ctrl  = 4'b1010;
                imm_src_d          = 3'b100;
            end
            7'b0010111: begin
                w_ctrl_d.reg_write = 1'b1;
                w_ctrl_d.alu_src   = 1'b1;
                imm_src_d          = 3'b100;
            end
            default: illegal_d = 1'b1;
        endcase
        w_ctrl_d.rd = w_ctrl_d.reg_write ? REG_ADDR_W'(instr_d[11:7]) : '0;
    end

    // Unused source fields read as x0 so they can never match a destination
    assign w_rs1_d = w_use1 ? REG_ADDR_W'(instr_d[19:15]) : '0;
    assign w_rs2_d = w_use2 ? REG_ADDR_W'(instr_d[24:20]) : '0;
    assign w_hit_e = r_e.rd != '0 && (r_e.rd == w_rs1_d || r_e.rd == w_rs2_d);

`ifdef FORWARD_EN
    logic [REG_ADDR_W-1:0] r_rs1_e;
    logic [REG_ADDR_W-1:0] r_rs2_e;

    // Execute-stage source registers, bubbled alongside the control bundle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs1_e <= '0;
            r_rs2_e <= '0;
        end else begin
            r_rs1_e <= flush_e ? '0 : w_rs1_d;
            r_rs2_e <= flush_e ? '0 : w_rs2_d;
        end
    end

    assign w_stall     = r_e.result_src == 2'b01 && w_hit_e;
    assign forward_a_e = (r_reg_write_m && r_rd_m != '0 && r_rd_m == r_rs1_e) ? 2'b10 :
                         (r_reg_write_w && r_rd_w != '0 && r_rd_w == r_rs1_e) ? 2'b01 : 2'b00;
    assign forward_b_e = (r_reg_write_m && r_rd_m != '0 && r_rd_m == r_rs2_e) ? 2'b10 :
                         (r_reg_write_w && r_rd_w != '0 && r_rd_w == r_rs2_e) ? 2'b01 : 2'b00;
`else
    logic w_hit_m;

    assign w_hit_m     = r_rd_m != '0 && (r_rd_m == w_rs1_d || r_rd_m == w_rs2_d);
    assign w_stall     = (r_e.reg_write && w_hit_e) || (r_reg_write_m && w_hit_m);
    assign forward_a_e = 2'b00;
    assign forward_b_e = 2'b00;
`endif

    assign pc_src_e = r_e.jump | (r_e.branch & (zero_e ^ r_e.f3b0));
    assign stall_f  = w_stall & ~pc_src_e;
    assign stall_d  = w_stall & ~pc_src_e;
    assign flush_d  = pc_src_e;
    assign flush_e  = w_stall | pc_src_e;

    // ID/EX: take the decoded bundle, or a bubble when Execute is flushed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_e <= '0;
        else
            r_e <= flush_e ? '0 : w_ctrl_d;
    end

    // EX/MEM and MEM/WB advance unconditionally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_rd_m         <= '0;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= 2'b00;
            r_rd_w         <= '0;
        end else begin
            r_reg_write_m  <= r_e.reg_write;
            r_mem_write_m  <= r_e.mem_write;
            r_result_src_m <= r_e.result_src;
            r_rd_m         <= r_e.rd;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
            r_rd_w         <= r_rd_m;
        end
    end

    assign reg_write_e   = r_e.reg_write;
    assign alu_control_e = ALU_CTRL_W'(r_e.alu_ctrl);
    assign alu_src_e     = r_e.alu_src;
    assign jalr_e        = r_e.jalr;
    assign rd_e          = r_e.rd;
    assign reg_write_m   = r_reg_write_m;
    assign mem_write_m   = r_mem_write_m;
    assign rd_m          = r_rd_m;
    assign reg_write_w   = r_reg_write_w;
    assign result_src_w  = r_result_src_w;
    assign rd_w          = r_rd_w;
endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

- Parametrised successor to the single-cycle RV32I control path.
- Decodes the instruction in the Decode stage and carries its control bundle through registered ID/EX, EX/MEM and MEM/WB stages.
- Adds hazard handling: load-use stall, branch/jump flush and operand forwarding select.
- Sits between the IF/ID instruction register and the datapath's ALU, memory and writeback muxes.

## Interface
Parameters:
- ALU_CTRL_W, 4, ALU control width; must be ≥4.
- REG_ADDR_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr_d  in  32  instruction in Decode
- zero_e  in  1  ALU zero flag of the instruction in Execute
- reg_write_e / reg_write_m / reg_write_w  out  1 each  stage register-write enables
- alu_control_e  out  ALU_CTRL_W  ALU operation in Execute
- alu_src_e  out  1  ALU operand B select: 1 = immediate
- imm_src_d  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- mem_write_m  out  1  data-memory write
- result_src_w  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4
- rd_e / rd_m / rd_w  out  REG_ADDR_W each  destination register per stage
- pc_src_e  out  1  redirect PC to the branch/jump target
- jalr_e  out  1  target base is rs1 rather than PC
- stall_f, stall_d  out  1 each  hold PC and IF/ID
- flush_d, flush_e  out  1 each  zero IF/ID and ID/EX
- forward_a_e, forward_b_e  out  2 each  operand select: 00 register file, 01 writeback, 10 memory stage
- illegal_d  out  1  unsupported opcode in Decode

## Operation
- **Decode (combinational on instr_d).** Supported opcodes: R (0110011), I-ALU (0010011), load (0000011), store (0100011), branch (1100011, BEQ/BNE only), JAL, JALR, LUI, AUIPC.
- **ALU control encoding.**
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu, 1010 pass-B (used by LUI).
  - Codes are zero-extended to ALU_CTRL_W.
- **Subtract and shift selection.**
  - Subtract applies only when the opcode is R-type and funct7[5]=1.
  - sra is selected when funct3=101 and funct7[5]=1.
- **Unsupported opcodes.** All control fields decode to 0 (a bubble) and illegal_d=1.
- **Pipeline registers.**
  - Each register holds the full control bundle, rd, rs1 and rs2 (the latter two in ID/EX only), branch, jump, jalr and funct3[0].
  - Registers advance every clock unless a stall or flush rule below applies.
- **Branch/jump resolution.**
  - pc_src_e = jump_e | (branch_e & (zero_e ^ funct3_e[0])).
  - When pc_src_e=1: flush_d=1 and flush_e=1.
- **Load-use hazard.**
  - Condition: result_src_e=01, rd_e≠0, and rd_e equals rs1_d or rs2_d (only for sources actually used by the opcode).
  - Response: stall_f=1, stall_d=1, flush_e=1.
- **Simultaneous stall and flush.** pc_src_e=1 and a load-use stall are mutually exclusive, because Execute cannot hold both a load and a branch. If both are ever asserted, the flush wins and stall_f/stall_d are forced to 0.
- **Writes to x0.** Any rd of 0 never triggers a hazard or a forward.

## Timing
- **Reset.** rst=0 clears all pipeline registers asynchronously, so every registered output is 0, including pc_src_e, forward_* and rd_*.
- **Decode-stage outputs.** imm_src_d and illegal_d are combinational from instr_d; their value during reset follows instr_d.
- **Latency.** Decode → Execute controls 1 cycle; → Memory 2 cycles; → Writeback 3 cycles.
- **Stall and flush outputs.** stall_* and flush_* are combinational in the same cycle as the hazard; they take effect at the next rising edge.
- **Bubble insertion.** A flushed ID/EX register loads the all-zero bundle. EX/MEM and MEM/WB never stall.
- **Reset deasserted mid-pipeline.** The pipeline refills with bubbles; the first valid writeback occurs 3 cycles after the first decoded instruction.

## Configuration
- **FORWARD_EN defined.**
  - forward_a_e = 10 if reg_write_m, rd_m≠0 and rd_m=rs1_e; otherwise 01 if reg_write_w, rd_w≠0 and rd_w=rs1_e; otherwise 00.
  - forward_b_e follows the same rule with rs2_e.
  - The Memory-stage match takes priority over the Writeback-stage match.
- **FORWARD_EN undefined.**
  - forward_a_e and forward_b_e are tied to 00.
  - Any used Decode source matching rd_e (reg_write_e=1) or rd_m (reg_write_m=1), with rd≠0, asserts stall_f, stall_d and flush_e.
  - Writeback needs no stall because the register file writes in the first half-cycle.

## Test plan
- Reset: assert rst=0 mid-stream → all registered outputs 0 immediately; release, then `add x3,x1,x2` → reg_write_w=1, rd_w=3 after 3 cycles.
- Decode check: `sub x5,x6,x7` → alu_control_e=0001; `addi x5,x6,-1` with funct7-field bit5 set → 0000; `srai` → 1000; `lui` → 1010 with imm_src 100.
- Load-use: `lw x4,0(x1)` then `add x5,x4,x2` → stall_f=stall_d=flush_e=1 for exactly one cycle. With FORWARD_EN, the add then sees forward_a_e=01.
- Branch: BNE with zero_e=0 → pc_src_e=1, flush_d=flush_e=1 for one cycle; BEQ with zero_e=0 → no flush.
- Forwarding (FORWARD_EN): `add x3,..` then `add x4,x3,x3` → forward_a_e=forward_b_e=10. A write to x0 followed by a use of x0 → 00.
- Illegal opcode 1111111 → illegal_d=1 and a bubble reaches Writeback with reg_write_w=0, mem_write_m=0.
